in_port_buffer: RTL

//   Input-port peripheral feeding the CPU datapath bus for the "in Ra" instruction.

---
 rtl/in_port_if.sv | 29 ++
 rtl/in_port_buffer.sv | 105 ++++++++++
 2 files changed

// File: rtl/in_port_if.sv
// Device/CPU-side signal bundle of the input-port buffer.
// Valid/ready convention: the device holds InputDev valid from Strobe rise until it sees Ack;
// the buffer accepts exactly one word per Strobe pulse and the CPU consumes the head word
// on the falling edge of InPortout.
interface in_port_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] InputDev;
  logic              Strobe;
  logic              Ack;
  logic              InPortout;
  logic [DATA_W-1:0] BusMuxIn_InPort;
  logic              DataValid;
  logic              Full;
  logic [CW-1:0]     Count;

  modport master (
    output InputDev, Strobe, InPortout,
    input  Ack, BusMuxIn_InPort, DataValid, Full, Count
  );

  modport slave (
    input  InputDev, Strobe, InPortout,
    output Ack, BusMuxIn_InPort, DataValid, Full, Count
  );
endinterface

// File: rtl/in_port_buffer.sv
// Input-port buffer: captures device words over a 4-phase Strobe/Ack handshake into a
// small first-word-fall-through FIFO whose head feeds the CPU bus mux.
module in_port_buffer #(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic       Clock,
  input  logic       Clear,
  in_port_if.slave   port_if,
  output logic       dbg_state_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } state_e;

  state_e                  state_q;
  logic                    ack_q;
  logic [SYNC_STAGES-1:0]  sync_q;
  logic                    inport_q;
  logic [AW-1:0]           wptr_q;
  logic [AW-1:0]           rptr_q;
  logic [CW-1:0]           count_q;
  logic [CW-1:0]           count_d;
  logic [DATA_W-1:0]       mem_q [DEPTH];

  logic strobe_s;
  logic full;
  logic not_empty;
  logic push;
  logic pop;

  assign strobe_s  = sync_q[SYNC_STAGES-1];
  assign full      = (count_q == CW'(DEPTH));
  assign not_empty = (count_q != '0);
  // Full is judged before any same-edge pop, so a stalled word lands one edge after the pop.
  assign push      = (state_q == ST_IDLE) && strobe_s && !full;
  assign pop       = inport_q && !port_if.InPortout && not_empty;

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (!push && pop) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge Clock) begin
    if (!Clear) begin
      sync_q   <= '0;
      state_q  <= ST_IDLE;
      ack_q    <= 1'b0;
      inport_q <= 1'b0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
    end else begin
      sync_q[0] <= port_if.Strobe;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      inport_q <= port_if.InPortout;
      count_q  <= count_d;
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      case (state_q)
        ST_IDLE: begin
          if (push) begin
            ack_q   <= 1'b1;
            state_q <= ST_ACK;
          end
        end
        ST_ACK: begin
          if (!strobe_s) begin
            ack_q   <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          ack_q   <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Storage is deliberately left uncleared; pointers and count define what is valid.
  always_ff @(posedge Clock) begin
    if (Clear && push) begin
      mem_q[wptr_q] <= port_if.InputDev;
    end
  end

  assign port_if.Ack             = ack_q;
  assign port_if.Count           = count_q;
  assign port_if.Full            = full;
  assign port_if.DataValid       = not_empty;
  assign port_if.BusMuxIn_InPort = not_empty ? mem_q[rptr_q] : '0;
  assign dbg_state_o             = state_q;
endmodule
